// File: rtl/lc3_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lc3_mem_pkg
//  Description : Shared types and constants for the LC3 memory responder:
//                FSM state encoding, arbitration grant encoding, latency
//                counter width and default word-address width.
//  Revision    : 1.0 - initial release
// ============================================================================
package lc3_mem_pkg;

    // Default number of word-address bits (array depth 2**c_ADDR_W_DEF)
    localparam int unsigned c_ADDR_W_DEF = 8;

    // Latency counter width; holds LAT-1 for LAT in 1..15
    localparam int unsigned c_LAT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } state_t;

    typedef enum logic {
        GR_INSTR = 1'b0,
        GR_DATA  = 1'b1
    } grant_t;

endpackage
`default_nettype wire

// File: rtl/lc3_mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : lc3_mem_array
//  Description : Single-port 2**ADDR_W x 16 word storage. Synchronous write,
//                combinational read on the shared port address. When
//                LC3_MEM_BACKDOOR_EN is defined a backdoor load port is muxed
//                onto the write side and wins over a same-edge port write.
//  Revision    : 1.0 - initial release
// ============================================================================
module lc3_mem_array
    import lc3_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = c_ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [15:0]       i_wdata,
    output logic [15:0]       o_rdata
`ifdef LC3_MEM_BACKDOOR_EN
    ,
    input  logic              i_ld_en,
    input  logic [ADDR_W-1:0] i_ld_addr,
    input  logic [15:0]       i_ld_data
`endif
);

    logic [15:0]       r_mem [0:(1<<ADDR_W)-1];
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [15:0]       w_wdata;

`ifdef LC3_MEM_BACKDOOR_EN
    // Backdoor load takes the write port; a clashing port write is dropped
    always_comb begin
        w_we    = i_we | i_ld_en;
        w_waddr = i_ld_en ? i_ld_addr : i_addr;
        w_wdata = i_ld_en ? i_ld_data : i_wdata;
    end
`else
    // Only the data channel writes the array
    always_comb begin
        w_we    = i_we;
        w_waddr = i_addr;
        w_wdata = i_wdata;
    end
`endif

    // Synchronous write; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/lc3_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : lc3_mem_responder
//  Description : Memory-side responder for the LC3 fetch and memory stages.
//                Serves instruction fetches and data reads/writes from one
//                unified single-port array with programmable wait states,
//                round-robin arbitration on conflicts and one-cycle
//                completion pulses. Optional backdoor load port enabled by
//                the macro LC3_MEM_BACKDOOR_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module lc3_mem_responder
    import lc3_mem_pkg::*;
#(
    parameter int unsigned ADDR_W    = c_ADDR_W_DEF,
    parameter int unsigned INSTR_LAT = 1,
    parameter int unsigned DATA_LAT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pc,
    input  logic        instrmem_rd,
    output logic [15:0] Instr_dout,
    output logic        complete_instr,
    input  logic        mem_req,
    input  logic [15:0] Data_addr,
    input  logic        Data_rd,
    input  logic [15:0] Data_din,
    output logic [15:0] Data_dout,
    output logic        complete_data
`ifdef LC3_MEM_BACKDOOR_EN
    ,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [15:0]       ld_data
`endif
);

    localparam logic [c_LAT_W-1:0] c_ILAT_M1 = c_LAT_W'(INSTR_LAT - 1);
    localparam logic [c_LAT_W-1:0] c_DLAT_M1 = c_LAT_W'(DATA_LAT - 1);

    state_t              r_state, w_state_nxt;
    grant_t              r_last, w_last_nxt;
    logic [c_LAT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_rd;
    logic [15:0]         r_din;
    logic                w_acc_i, w_acc_d;
    logic                w_svc_i, w_svc_d;
    logic                w_we;
    logic [15:0]         w_rdata;

    // Upper address bits alias onto the array and are intentionally ignored
    generate
        if (ADDR_W < 16) begin : g_addr_hi
            logic w_unused_addr_hi;
            assign w_unused_addr_hi = ^{pc[15:ADDR_W], Data_addr[15:ADDR_W]};
        end
    endgenerate

    // Next-state, arbitration and counter control
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        w_acc_i     = 1'b0;
        w_acc_d     = 1'b0;
        w_svc_i     = 1'b0;
        w_svc_d     = 1'b0;
        case (r_state)
            IDLE: begin
                // On conflict the channel not granted last time wins
                if (mem_req && (!instrmem_rd || (r_last == GR_INSTR))) begin
                    w_acc_d     = 1'b1;
                    w_state_nxt = D_BUSY;
                    w_cnt_nxt   = c_DLAT_M1;
                    w_last_nxt  = GR_DATA;
                end else if (instrmem_rd) begin
                    w_acc_i     = 1'b1;
                    w_state_nxt = I_BUSY;
                    w_cnt_nxt   = c_ILAT_M1;
                    w_last_nxt  = GR_INSTR;
                end
            end
            I_BUSY, D_BUSY: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - c_LAT_W'(1);
                end else begin
                    w_svc_i     = (r_state == I_BUSY);
                    w_svc_d     = (r_state == D_BUSY);
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Data writes commit in the service cycle from the latched request
    assign w_we = w_svc_d & ~r_rd;

    // FSM state, latency counter and round-robin history
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_last  <= GR_INSTR;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Capture the accepted request; inputs are ignored while busy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr <= '0;
            r_rd   <= 1'b0;
            r_din  <= '0;
        end else if (w_acc_d) begin
            r_addr <= Data_addr[ADDR_W-1:0];
            r_rd   <= Data_rd;
            r_din  <= Data_din;
        end else if (w_acc_i) begin
            r_addr <= pc[ADDR_W-1:0];
        end
    end

    // Registered read data and completion pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Instr_dout     <= '0;
            Data_dout      <= '0;
            complete_instr <= 1'b0;
            complete_data  <= 1'b0;
        end else begin
            complete_instr <= w_svc_i;
            complete_data  <= w_svc_d;
            if (w_svc_i) begin
                Instr_dout <= w_rdata;
            end
            if (w_svc_d && r_rd) begin
                Data_dout <= w_rdata;
            end
        end
    end

    lc3_mem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk       (clk),
        .i_we      (w_we),
        .i_addr    (r_addr),
        .i_wdata   (r_din),
        .o_rdata   (w_rdata)
`ifdef LC3_MEM_BACKDOOR_EN
        ,
        .i_ld_en   (ld_en),
        .i_ld_addr (ld_addr),
        .i_ld_data (ld_data)
`endif
    );

endmodule
`default_nettype wire

// File: tb/tb_lc3_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lc3_mem_responder
//  Description : Self-checking bench for lc3_mem_responder. A transaction
//                level model predicts outputs every cycle; directed
//                sequences add literal expectations. Backdoor sequence runs
//                when LC3_MEM_BACKDOOR_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lc3_mem_responder;

    localparam int ADDR_W    = 8;
    localparam int INSTR_LAT = 1;
    localparam int DATA_LAT  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pc = '0;
    logic        instrmem_rd = 1'b0;
    logic [15:0] Instr_dout;
    logic        complete_instr;
    logic        mem_req = 1'b0;
    logic [15:0] Data_addr = '0;
    logic        Data_rd = 1'b0;
    logic [15:0] Data_din = '0;
    logic [15:0] Data_dout;
    logic        complete_data;
`ifdef LC3_MEM_BACKDOOR_EN
    logic              ld_en = 1'b0;
    logic [ADDR_W-1:0] ld_addr = '0;
    logic [15:0]       ld_data = '0;
`endif

    int n_vec = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    lc3_mem_responder #(
        .ADDR_W    (ADDR_W),
        .INSTR_LAT (INSTR_LAT),
        .DATA_LAT  (DATA_LAT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pc             (pc),
        .instrmem_rd    (instrmem_rd),
        .Instr_dout     (Instr_dout),
        .complete_instr (complete_instr),
        .mem_req        (mem_req),
        .Data_addr      (Data_addr),
        .Data_rd        (Data_rd),
        .Data_din       (Data_din),
        .Data_dout      (Data_dout),
        .complete_data  (complete_data)
`ifdef LC3_MEM_BACKDOOR_EN
        ,
        .ld_en          (ld_en),
        .ld_addr        (ld_addr),
        .ld_data        (ld_data)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: no completion pulse within budget at %0t", name, $time);
    endtask

    // ---------------- transaction-level reference model ----------------
    // A request seen at an edge while the responder is free is accepted and
    // completes LAT edges later; the next edge is free again.
    logic [15:0] m_mem [0:255];
    bit          m_busy, m_is_data, m_rd, m_last_data;
    logic [7:0]  m_addr;
    logic [15:0] m_din;
    int          m_cyc = 0, m_due = 0;
    logic [15:0] e_instr = '0, e_dout = '0;
    bit          e_ci = 1'b0, e_cd = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy      = 1'b0;
            m_last_data = 1'b0;
            e_instr     = '0;
            e_dout      = '0;
            e_ci        = 1'b0;
            e_cd        = 1'b0;
        end else begin
            m_cyc++;
            e_ci = 1'b0;
            e_cd = 1'b0;
            if (m_busy) begin
                if (m_cyc == m_due) begin
                    m_busy = 1'b0;
                    if (!m_is_data) begin
                        e_instr = m_mem[m_addr];
                        e_ci    = 1'b1;
                    end else begin
                        e_cd = 1'b1;
                        if (m_rd) e_dout = m_mem[m_addr];
                        else      m_mem[m_addr] = m_din;
                    end
                end
            end else if (mem_req || instrmem_rd) begin
                m_is_data   = mem_req && (!instrmem_rd || !m_last_data);
                m_last_data = m_is_data;
                m_busy      = 1'b1;
                m_addr      = m_is_data ? Data_addr[7:0] : pc[7:0];
                m_rd        = Data_rd;
                m_din       = Data_din;
                m_due       = m_cyc + (m_is_data ? DATA_LAT : INSTR_LAT);
            end
        end
`ifdef LC3_MEM_BACKDOOR_EN
        if (ld_en) m_mem[ld_addr] = ld_data;
`endif
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_on) begin
            check("Instr_dout",     Instr_dout,     e_instr);
            check("Data_dout",      Data_dout,      e_dout);
            check("complete_instr", complete_instr, e_ci);
            check("complete_data",  complete_data,  e_cd);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic txn_data(input logic [15:0] a, input bit rd, input logic [15:0] d, output int lat);
        @(negedge clk);
        mem_req = 1'b1; Data_addr = a; Data_rd = rd; Data_din = d;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (complete_data) begin lat = i; break; end
        end
        mem_req = 1'b0;
        if (lat < 0) timeout("data_txn");
    endtask

    task automatic txn_fetch(input logic [15:0] a, output int lat);
        @(negedge clk);
        instrmem_rd = 1'b1; pc = a;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (complete_instr) begin lat = i; break; end
        end
        instrmem_rd = 1'b0;
        if (lat < 0) timeout("fetch_txn");
    endtask

    // Both channels raised together and held; first = 1 data, 2 instr
    task automatic txn_pair(input logic [15:0] fpc, input logic [15:0] daddr, output int first);
        bit seen_i;
        bit seen_d;
        seen_i = 1'b0; seen_d = 1'b0; first = 0;
        @(negedge clk);
        instrmem_rd = 1'b1; pc = fpc;
        mem_req = 1'b1; Data_addr = daddr; Data_rd = 1'b1;
        for (int i = 0; i < 60 && !(seen_i && seen_d); i++) begin
            @(negedge clk);
            if (complete_data)  begin mem_req = 1'b0;     seen_d = 1'b1; if (first == 0) first = 1; end
            if (complete_instr) begin instrmem_rd = 1'b0; seen_i = 1'b1; if (first == 0) first = 2; end
        end
        instrmem_rd = 1'b0; mem_req = 1'b0;
        if (!(seen_i && seen_d)) timeout("pair_txn");
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int lat;
        int first;
        int pulses;

        // 1: reset held three cycles, then idle
        #1 reset = 1'b0;
        @(negedge clk);
        chk_on = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_instr_dout", Instr_dout, 16'h0000);
        check("rst_data_dout",  Data_dout,  16'h0000);
        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_pulses", {complete_instr, complete_data}, 2'b00);

        // 2: write then read back at 0x0010
        txn_data(16'h0010, 1'b0, 16'h1234, lat);
        check("wr_latency", lat, DATA_LAT);
        txn_data(16'h0010, 1'b1, 16'h0000, lat);
        check("rd_latency", lat, DATA_LAT);
        check("rd_value",   Data_dout, 16'h1234);

        // 3: write an instruction, fetch it
        txn_data(16'h0000, 1'b0, 16'h5020, lat);
        txn_fetch(16'h0000, lat);
        check("fetch_latency", lat, INSTR_LAT);
        check("fetch_value",   Instr_dout, 16'h5020);

        // aliasing: 0x0110 hits the same word as 0x0010
        txn_data(16'h0110, 1'b1, 16'h0000, lat);
        check("alias_rd_value", Data_dout, 16'h1234);

        // 4: last grant was data (alias read), so a conflict goes to instr;
        // a lone fetch then makes the following conflict go to data
        txn_data(16'h0040, 1'b0, 16'hA5A5, lat);
        txn_pair(16'h0040, 16'h0010, first);
        check("pair_after_data_first", first, 2);
        check("pair_instr_value", Instr_dout, 16'hA5A5);
        txn_fetch(16'h0000, lat);
        txn_pair(16'h0000, 16'h0040, first);
        check("pair_after_instr_first", first, 1);
        check("pair_data_value", Data_dout, 16'hA5A5);

        // 5: write aborted by reset mid-busy leaves the word unchanged
        txn_data(16'h0020, 1'b0, 16'h0000, lat);
        @(negedge clk);
        mem_req = 1'b1; Data_addr = 16'h0020; Data_rd = 1'b0; Data_din = 16'hBEEF;
        @(negedge clk);
        #2 reset = 1'b0;
        mem_req = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (complete_data) pulses++;
        end
        #2 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (complete_data) pulses++;
        end
        check("abort_no_pulse", pulses, 0);
        check("abort_dout_reset", Data_dout, 16'h0000);
        txn_data(16'h0020, 1'b1, 16'h0000, lat);
        check("abort_word_kept", Data_dout, 16'h0000);

`ifdef LC3_MEM_BACKDOOR_EN
        // 6: backdoor load then aliased fetch
        @(negedge clk);
        ld_en = 1'b1; ld_addr = 8'h30; ld_data = 16'h0FFF;
        @(negedge clk);
        ld_en = 1'b0;
        txn_fetch(16'h0130, lat);
        check("backdoor_fetch", Instr_dout, 16'h0FFF);
`endif

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
